// File: rtl/ex_stage.sv
// Execute stage: logic/move/link result, same-cycle forwarding triple,
// EX/MEM pipeline register and the architectural HI/LO registers.
module ex_stage #(
  parameter logic [31:0] HILO_INIT  = 32'h0,
  parameter bit          ZERO_GUARD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [2:0]  alusel_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] link_addr_i,
  input  logic        is_in_delayslot_i,
  output logic        ex_wreg_o,
  output logic [4:0]  ex_wd_o,
  output logic [31:0] ex_wdata_o,
  output logic        mem_wreg_o,
  output logic [4:0]  mem_wd_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_is_in_delayslot_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  // Shared op-class and operation encodings
  localparam logic [2:0] RES_LOGIC       = 3'b001;
  localparam logic [2:0] RES_MOVE        = 3'b011;
  localparam logic [2:0] RES_JUMP_BRANCH = 3'b110;

  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOR  = 8'b0010_0111;
  localparam logic [7:0] OP_ANDI = 8'b0101_1001;
  localparam logic [7:0] OP_ORI  = 8'b0101_1010;
  localparam logic [7:0] OP_XORI = 8'b0101_1011;
  localparam logic [7:0] OP_LUI  = 8'b0101_1100;
  localparam logic [7:0] OP_MFHI = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO = 8'b0001_0011;

  logic [31:0] result;
  logic        valid;
  logic        hi_we;
  logic        lo_we;

  logic        mem_wreg_d,  mem_wreg_q;
  logic [4:0]  mem_wd_d,    mem_wd_q;
  logic [31:0] mem_wdata_d, mem_wdata_q;
  logic        mem_ds_d,    mem_ds_q;
  logic [31:0] hi_d,        hi_q;
  logic [31:0] lo_d,        lo_q;

  // Decode op class/operation into a result, a validity flag and HI/LO write strobes
  always_comb begin
    result = '0;
    valid  = 1'b0;
    hi_we  = 1'b0;
    lo_we  = 1'b0;
    case (alusel_i)
      RES_LOGIC: begin
        valid = 1'b1;
        case (aluop_i)
          OP_AND, OP_ANDI: result = reg1_i & reg2_i;
          OP_OR,  OP_ORI:  result = reg1_i | reg2_i;
          OP_XOR, OP_XORI: result = reg1_i ^ reg2_i;
          OP_NOR:          result = ~(reg1_i | reg2_i);
          OP_LUI:          result = reg2_i;
          default:         valid  = 1'b0;
        endcase
      end
      RES_MOVE: begin
        case (aluop_i)
          OP_MFHI: begin result = hi_q; valid = 1'b1; end
          OP_MFLO: begin result = lo_q; valid = 1'b1; end
          OP_MTHI: hi_we = 1'b1;
          OP_MTLO: lo_we = 1'b1;
          default: ;
        endcase
      end
      RES_JUMP_BRANCH: begin
        result = link_addr_i;
        valid  = 1'b1;
      end
      default: ;
    endcase
  end

  // Forwarding triple back to decode
  always_comb begin
    ex_wd_o    = wd_i;
    ex_wdata_o = result;
    ex_wreg_o  = wreg_i & valid & ~(ZERO_GUARD & (wd_i == 5'd0));
  end

  // Next state for EX/MEM and HI/LO: flush beats stall beats load
  always_comb begin
    mem_wreg_d  = mem_wreg_q;
    mem_wd_d    = mem_wd_q;
    mem_wdata_d = mem_wdata_q;
    mem_ds_d    = mem_ds_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    if (flush) begin
      mem_wreg_d  = 1'b0;
      mem_wd_d    = '0;
      mem_wdata_d = '0;
      mem_ds_d    = 1'b0;
    end else if (!stall) begin
      mem_wreg_d  = ex_wreg_o;
      mem_wd_d    = ex_wd_o;
      mem_wdata_d = ex_wdata_o;
      mem_ds_d    = is_in_delayslot_i;
      if (hi_we) hi_d = reg1_i;
      if (lo_we) lo_d = reg1_i;
    end
  end

  // Pipeline and HI/LO state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wreg_q  <= 1'b0;
      mem_wd_q    <= '0;
      mem_wdata_q <= '0;
      mem_ds_q    <= 1'b0;
      hi_q        <= HILO_INIT;
      lo_q        <= HILO_INIT;
    end else begin
      mem_wreg_q  <= mem_wreg_d;
      mem_wd_q    <= mem_wd_d;
      mem_wdata_q <= mem_wdata_d;
      mem_ds_q    <= mem_ds_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign mem_wreg_o            = mem_wreg_q;
  assign mem_wd_o              = mem_wd_q;
  assign mem_wdata_o           = mem_wdata_q;
  assign mem_is_in_delayslot_o = mem_ds_q;
  assign hi_o                  = hi_q;
  assign lo_o                  = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table plus stall/flush/reset sequences.
module tb_ex_stage;

  localparam logic [2:0] C_NOP   = 3'b000;
  localparam logic [2:0] C_LOGIC = 3'b001;
  localparam logic [2:0] C_MOVE  = 3'b011;
  localparam logic [2:0] C_JB    = 3'b110;

  localparam logic [7:0] O_AND  = 8'b0010_0100;
  localparam logic [7:0] O_OR   = 8'b0010_0101;
  localparam logic [7:0] O_XOR  = 8'b0010_0110;
  localparam logic [7:0] O_NOR  = 8'b0010_0111;
  localparam logic [7:0] O_ORI  = 8'b0101_1010;
  localparam logic [7:0] O_LUI  = 8'b0101_1100;
  localparam logic [7:0] O_MFHI = 8'b0001_0000;
  localparam logic [7:0] O_MTHI = 8'b0001_0001;
  localparam logic [7:0] O_MTLO = 8'b0001_0011;
  localparam logic [7:0] O_JAL  = 8'b0101_0000;
  localparam logic [7:0] O_J    = 8'b0100_1111;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [2:0]  alusel_i;
  logic [7:0]  aluop_i;
  logic [31:0] reg1_i, reg2_i, link_addr_i;
  logic [4:0]  wd_i;
  logic        wreg_i, is_in_delayslot_i;
  logic        ex_wreg_o, mem_wreg_o, mem_is_in_delayslot_o;
  logic [4:0]  ex_wd_o, mem_wd_o;
  logic [31:0] ex_wdata_o, mem_wdata_o, hi_o, lo_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_stage #(.HILO_INIT(32'h0), .ZERO_GUARD(1'b1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .alusel_i(alusel_i), .aluop_i(aluop_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .link_addr_i(link_addr_i),
    .is_in_delayslot_i(is_in_delayslot_i),
    .ex_wreg_o(ex_wreg_o), .ex_wd_o(ex_wd_o), .ex_wdata_o(ex_wdata_o),
    .mem_wreg_o(mem_wreg_o), .mem_wd_o(mem_wd_o), .mem_wdata_o(mem_wdata_o),
    .mem_is_in_delayslot_o(mem_is_in_delayslot_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  typedef struct {
    string       name;
    logic [2:0]  sel;
    logic [7:0]  op;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] link;
    logic        ds;
    logic        exp_wreg;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] link, input logic ds);
    alusel_i = sel; aluop_i = op; reg1_i = r1; reg2_i = r2;
    wd_i = wd; wreg_i = wreg; link_addr_i = link; is_in_delayslot_i = ds;
  endtask

  // Advance one rising edge and sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"ori",      C_LOGIC, O_ORI,  32'h0000_00F0, 32'h0000_000F, 5'd5,  1'b1, 32'h0,     1'b0, 1'b1, 32'h0000_00FF};
    vecs[1]  = '{"nor",      C_LOGIC, O_NOR,  32'hFFFF_0000, 32'h0000_00FF, 5'd6,  1'b1, 32'h0,     1'b0, 1'b1, 32'h0000_FF00};
    vecs[2]  = '{"lui",      C_LOGIC, O_LUI,  32'h0,         32'h1234_0000, 5'd7,  1'b1, 32'h0,     1'b0, 1'b1, 32'h1234_0000};
    vecs[3]  = '{"and",      C_LOGIC, O_AND,  32'h0F0F_0F0F, 32'h00FF_00FF, 5'd9,  1'b1, 32'h0,     1'b0, 1'b1, 32'h000F_000F};
    vecs[4]  = '{"xor_ds",   C_LOGIC, O_XOR,  32'hA5A5_A5A5, 32'hFFFF_0000, 5'd10, 1'b1, 32'h0,     1'b1, 1'b1, 32'h5A5A_A5A5};
    vecs[5]  = '{"jal",      C_JB,    O_JAL,  32'h0,         32'h0,         5'd31, 1'b1, 32'h108,   1'b0, 1'b1, 32'h0000_0108};
    vecs[6]  = '{"j_ds",     C_JB,    O_J,    32'h0,         32'h0,         5'd0,  1'b0, 32'h200,   1'b1, 1'b0, 32'h0000_0200};
    vecs[7]  = '{"or_r0",    C_LOGIC, O_OR,   32'h0000_00F0, 32'h0000_000F, 5'd0,  1'b1, 32'h0,     1'b0, 1'b0, 32'h0000_00FF};
    vecs[8]  = '{"bad_op",   C_LOGIC, 8'hFF,  32'h1234_5678, 32'hFFFF_FFFF, 5'd3,  1'b1, 32'h0,     1'b0, 1'b0, 32'h0};
    vecs[9]  = '{"bad_sel",  3'b111,  O_OR,   32'h1234_5678, 32'hFFFF_FFFF, 5'd3,  1'b1, 32'h55,    1'b0, 1'b0, 32'h0};
    vecs[10] = '{"mfhi_rst", C_MOVE,  O_MFHI, 32'hFFFF_FFFF, 32'h0,         5'd4,  1'b1, 32'h0,     1'b0, 1'b1, 32'h0};

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(C_NOP, 8'h0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
    step(); step();
    chk("rst_mem_wreg", {31'b0, mem_wreg_o}, 32'h0);
    chk("rst_mem_wd", {27'b0, mem_wd_o}, 32'h0);
    chk("rst_mem_wdata", mem_wdata_o, 32'h0);
    chk("rst_mem_ds", {31'b0, mem_is_in_delayslot_o}, 32'h0);
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_lo", lo_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table: combinational result before the edge, EX/MEM copy after it
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i].sel, vecs[i].op, vecs[i].r1, vecs[i].r2, vecs[i].wd,
            vecs[i].wreg, vecs[i].link, vecs[i].ds);
      #1;
      chk({vecs[i].name, "_ex_wdata"}, ex_wdata_o, vecs[i].exp_data);
      chk({vecs[i].name, "_ex_wreg"}, {31'b0, ex_wreg_o}, {31'b0, vecs[i].exp_wreg});
      chk({vecs[i].name, "_ex_wd"}, {27'b0, ex_wd_o}, {27'b0, vecs[i].wd});
      step();
      chk({vecs[i].name, "_mem_wdata"}, mem_wdata_o, vecs[i].exp_data);
      chk({vecs[i].name, "_mem_wreg"}, {31'b0, mem_wreg_o}, {31'b0, vecs[i].exp_wreg});
      chk({vecs[i].name, "_mem_wd"}, {27'b0, mem_wd_o}, {27'b0, vecs[i].wd});
      chk({vecs[i].name, "_mem_ds"}, {31'b0, mem_is_in_delayslot_o}, {31'b0, vecs[i].ds});
    end

    // MTHI then MFHI back-to-back
    @(negedge clk);
    drive(C_MOVE, O_MTHI, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("mthi_ex_wreg", {31'b0, ex_wreg_o}, 32'h0);
    chk("mthi_ex_wdata", ex_wdata_o, 32'h0);
    step();
    chk("mthi_hi", hi_o, 32'hDEAD_BEEF);
    chk("mthi_lo_untouched", lo_o, 32'h0);
    @(negedge clk);
    drive(C_MOVE, O_MFHI, 32'h0, 32'h0, 5'd8, 1'b1, 32'h0, 1'b0);
    #1;
    chk("mfhi_ex_wdata", ex_wdata_o, 32'hDEAD_BEEF);
    chk("mfhi_ex_wreg", {31'b0, ex_wreg_o}, 32'h1);
    step();
    chk("mfhi_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    chk("mfhi_mem_wd", {27'b0, mem_wd_o}, 32'd8);

    // Stall held 3 cycles under MTLO: EX/MEM frozen, LO written only on release
    @(negedge clk);
    drive(C_LOGIC, O_ORI, 32'h0000_00F0, 32'h0000_000F, 5'd5, 1'b1, 32'h0, 1'b0);
    step();
    @(negedge clk);
    drive(C_MOVE, O_MTLO, 32'h7, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall_mem_wdata", mem_wdata_o, 32'h0000_00FF);
      chk("stall_mem_wd", {27'b0, mem_wd_o}, 32'd5);
      chk("stall_mem_wreg", {31'b0, mem_wreg_o}, 32'h1);
      chk("stall_lo", lo_o, 32'h0);
    end
    @(negedge clk);
    stall = 1'b0;
    step();
    chk("release_lo", lo_o, 32'h7);
    chk("release_mem_wreg", {31'b0, mem_wreg_o}, 32'h0);
    chk("release_mem_wdata", mem_wdata_o, 32'h0);

    // Stall+flush: bubble wins, HI/LO untouched
    @(negedge clk);
    drive(C_LOGIC, O_ORI, 32'h0000_00F0, 32'h0000_000F, 5'd5, 1'b1, 32'h0, 1'b1);
    step();
    @(negedge clk);
    drive(C_MOVE, O_MTLO, 32'h9, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1);
    stall = 1'b1; flush = 1'b1;
    step();
    chk("flush_mem_wreg", {31'b0, mem_wreg_o}, 32'h0);
    chk("flush_mem_wd", {27'b0, mem_wd_o}, 32'h0);
    chk("flush_mem_wdata", mem_wdata_o, 32'h0);
    chk("flush_mem_ds", {31'b0, mem_is_in_delayslot_o}, 32'h0);
    chk("flush_lo", lo_o, 32'h7);

    // Flush alone on an MTHI: HI not written
    @(negedge clk);
    stall = 1'b0;
    drive(C_MOVE, O_MTHI, 32'h1111_2222, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
    step();
    chk("flush_hi", hi_o, 32'hDEAD_BEEF);

    // Reset mid-stall while loaded with a live result
    @(negedge clk);
    flush = 1'b0;
    drive(C_LOGIC, O_ORI, 32'h0000_00F0, 32'h0000_000F, 5'd5, 1'b1, 32'h0, 1'b1);
    step();
    chk("pre_rst_mem_wdata", mem_wdata_o, 32'h0000_00FF);
    @(negedge clk);
    stall = 1'b1; rst = 1'b1;
    drive(C_MOVE, O_MTHI, 32'h55, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("rst_ex_wd_follows", {27'b0, ex_wd_o}, 32'h0);
    @(negedge clk);
    drive(C_LOGIC, O_ORI, 32'h0000_00F0, 32'h0000_000F, 5'd5, 1'b1, 32'h0, 1'b1);
    #1;
    chk("rst_ex_wdata_follows", ex_wdata_o, 32'h0000_00FF);
    step();
    chk("mid_rst_mem_wreg", {31'b0, mem_wreg_o}, 32'h0);
    chk("mid_rst_mem_wd", {27'b0, mem_wd_o}, 32'h0);
    chk("mid_rst_mem_wdata", mem_wdata_o, 32'h0);
    chk("mid_rst_mem_ds", {31'b0, mem_is_in_delayslot_o}, 32'h0);
    chk("mid_rst_hi", hi_o, 32'h0);
    chk("mid_rst_lo", lo_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
